// File: rtl/fetch_stall_flush_ctrl_pkg.sv
// Shared ISA constants and fetch-control FSM encoding for the front end.
package fetch_stall_flush_ctrl_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/dff_en.sv
// Generic register cell: synchronous active-high reset to RST_VAL, load when enabled.
module dff_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_stall_flush_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall/flush performance counts.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_en;

  // Stop counting once all-ones so the value sticks instead of wrapping.
  assign cnt_en = inc_i && (cnt_q != {CNT_W{1'b1}});

  dff_en #(.W(CNT_W), .RST_VAL('0)) u_cnt_reg (
    .clk_i (clk_i),
    .rst_i (clr_i),
    .en_i  (cnt_en),
    .d_i   (cnt_q + CNT_W'(1)),
    .q_o   (cnt_q)
  );

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stall_flush_ctrl.sv
// Fetch-side stall/wipe consumer: owns the PC and IF/ID register, handles redirects,
// freezes after HALT and keeps saturating stall/flush counters.
module fetch_stall_flush_ctrl
  import fetch_stall_flush_ctrl_pkg::*;
#(
  parameter int            PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             wipe,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic [PC_W-1:0]  instr_in,
  input  logic             halt_dec,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  instr_out,
  output logic [PC_W-1:0]  pc_plus2_out,
  output logic             valid_out,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e    state_q, state_d;
  logic [1:0]      state_raw;
  logic            in_halt;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus2;
  logic            pc_en;
  logic [PC_W-1:0] instr_q, instr_d, pp2_q, pp2_d;
  logic            valid_q, valid_d;

  assign state_q  = fetch_state_e'(state_raw);
  assign in_halt  = (state_q == ST_HALT);
  assign pc_plus2 = pc_q + PC_W'(2);

  // A wipe outranks stall and halt_dec, so a HALT on a squashed path never takes effect.
  always_comb begin
    state_d = ST_RUN;
    if (in_halt) begin
      state_d = ST_HALT;
    end else if (wipe) begin
      state_d = ST_FLUSH;
    end else if (stall) begin
      state_d = ST_STALL;
    end else if (halt_dec) begin
      state_d = ST_HALT;
    end
  end

  assign pc_en = !in_halt && (redirect || !(stall && !wipe));
  assign pc_d  = redirect ? redirect_pc : pc_plus2;

  always_comb begin
    instr_d = instr_q;
    pp2_d   = pp2_q;
    valid_d = valid_q;
    if (wipe || redirect) begin
      instr_d = PC_W'(NOP_INSTR);
      pp2_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (state_d == ST_HALT) begin
      instr_d = PC_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else begin
      instr_d = instr_in;
      pp2_d   = pc_plus2;
      valid_d = 1'b1;
    end
  end

  dff_en #(.W(2), .RST_VAL(ST_RUN)) u_state_reg (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .d_i (state_d), .q_o (state_raw)
  );

  dff_en #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk_i (clk), .rst_i (rst), .en_i (pc_en), .d_i (pc_d), .q_o (pc_q)
  );

  dff_en #(.W(PC_W), .RST_VAL(PC_W'(NOP_INSTR))) u_instr_reg (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .d_i (instr_d), .q_o (instr_q)
  );

  dff_en #(.W(PC_W), .RST_VAL('0)) u_pp2_reg (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .d_i (pp2_d), .q_o (pp2_q)
  );

  dff_en #(.W(1), .RST_VAL(1'b0)) u_valid_reg (
    .clk_i (clk), .rst_i (rst), .en_i (1'b1), .d_i (valid_d), .q_o (valid_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk), .clr_i (rst), .inc_i (stall && !wipe && !in_halt), .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk), .clr_i (rst), .inc_i (wipe && !in_halt), .cnt_o (flush_cnt)
  );

  assign pc           = pc_q;
  assign instr_out    = instr_q;
  assign pc_plus2_out = pp2_q;
  assign valid_out    = valid_q;
  assign halted       = in_halt;

endmodule

// File: doc/fetch_stall_flush_ctrl.md
Name: fetch_stall_flush_ctrl

Overview:
Fetch-side consumer of the decode-stage stall/wipe handshake. Owns the PC register and the IF/ID pipeline register. Holds both on stall, injects NOPs on wipe, and loads branch/jump redirect targets. Freezes the front end after HALT, and keeps saturating stall/flush cycle counters for performance debug.

Parameters:
PC_W, 16, PC and instruction width
RESET_PC, 16'h0000, PC value after reset
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset, sampled on rising clk
stall  in  1  RAW stall from decode hazard unit (already masked by ~wipe upstream)
wipe  in  1  control-hazard flush from decode hazard unit
redirect  in  1  taken branch/jump/JR from execute
redirect_pc  in  PC_W  target PC for redirect
instr_in  in  PC_W  instruction memory read data for current pc
halt_dec  in  1  decode holds a valid HALT (opcode 5'b00000)
pc  out  PC_W  current fetch PC to instruction memory
instr_out  out  PC_W  IF/ID instruction to decode
pc_plus2_out  out  PC_W  IF/ID PC+2 to decode
valid_out  out  1  IF/ID holds a real instruction (0 = injected NOP)
halted  out  1  front end frozen by HALT
stall_cnt  out  CNT_W  cycles spent in STALL, saturating
flush_cnt  out  CNT_W  cycles spent in FLUSH, saturating

Behaviour:
- Reset (sync, rst=1 at edge): pc=RESET_PC, instr_out=NOP_INSTR (16'h0800), pc_plus2_out=0, valid_out=0, halted=0, stall_cnt=0, flush_cnt=0, state=RUN. Reset overrides everything, including mid-flush and HALT.
- All outputs are registered. pc drives imem combinationally from the PC register. instr_in is the imem result for pc in the same cycle.
- FSM states are RUN, STALL, FLUSH, HALT. Transitions are evaluated every edge, and the first matching rule wins:
  1. halted state: stay HALT. Ignore stall, wipe and redirect.
  2. wipe=1 -> FLUSH.
  3. stall=1 -> STALL.
  4. halt_dec=1 -> HALT.
  5. Otherwise -> RUN.
- PC update, in priority order:
  1. HALT: hold.
  2. redirect=1: pc <= redirect_pc. Applies regardless of stall or wipe.
  3. stall=1 and wipe=0: hold.
  4. Otherwise: pc <= pc+2, modulo 2^PC_W (0xFFFE wraps to 0x0000).
- IF/ID update, in priority order:
  1. wipe=1 or redirect=1: instr_out<=NOP_INSTR, valid_out<=0, pc_plus2_out<=0.
  2. stall=1: hold all three.
  3. HALT (entered or resident): instr_out<=NOP_INSTR, valid_out<=0.
  4. Otherwise: instr_out<=instr_in, pc_plus2_out<=pc+2, valid_out<=1.
- halted is 1 from the edge that enters HALT until rst.
- Counters:
  - stall_cnt increments on each edge where stall=1 and wipe=0 and not halted.
  - flush_cnt increments on each edge where wipe=1 and not halted.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - stall and wipe together: treat as wipe, since a flush dominates.
  - halt_dec with stall: no HALT until the stall clears.
  - halt_dec with wipe: HALT is discarded, because it lies on a squashed path.
- Latency: redirect at edge N gives pc=redirect_pc after N, and the first valid target instruction in IF/ID after N+1 (if wipe is deasserted).

Decomposition:
- Shared package (isa_consts): NOP_INSTR=16'h0800, OP_HALT=5'b00000, OP_NOP=5'b00001, FSM state encodings (2-bit).
- Registers are built from the existing dff_en cell.
- One sub-module: sat_counter (CNT_W-bit, inc enable, sync clear), instantiated twice.

Test Plan:
- Reset then 4 free-run cycles with instr_in=pc-tagged values: pc steps 0,2,4,6,8. instr_out follows one cycle later; valid_out=1 from the 2nd edge.
- stall=1 for 2 cycles at pc=6: pc holds 6, instr_out holds, stall_cnt=2. On release pc=8 next edge.
- redirect=1, redirect_pc=0x0040 with wipe=1 for 3 cycles: pc=0x40,0x42,... valid_out=0 for 3 edges, flush_cnt=3, stall ignored during wipe.
- pc=0xFFFE free-run: next pc=0x0000, pc_plus2_out=0x0000.
- halt_dec=1 with stall=1, then stall=0: HALT is entered only after stall drops. halted=1, pc frozen, later redirect ignored. rst=1 mid-HALT restores pc=0, halted=0.
- Force stall_cnt to 0xFFFE, then stall 3 cycles: stall_cnt=0xFFFF and holds.
